uart_tx_queue: RTL and testbench
================================

// Module: uart_tx_queue
// PURPOSE
//  Byte queue that sits directly upstream of the UART transmitter (uart_tx inside uart_protocol).
//  A host writes bytes at clk rate; the block buffers them in a circular FIFO and drains them
//  one at a time into the transmitter's tx_start/tx_data inputs, paced by baud_tick_tx and tx_done.
//  This removes the need for the host to wait on each frame.
// PARAMETERS
//  data_len   8    width of each queued byte; must equal the transmitter's data_len
//  DEPTH      16   FIFO entries; power of 2, >= 2
//  ADDR_W     $clog2(DEPTH)   derived, pointer width; not overridden
// PORTS
//  clk           in   1         common system clock (50 MHz in the reference system)
//  rst           in   1         asynchronous, active-low reset (0 = reset)
//  wr_en         in   1         host write strobe, one byte per cycle
//  wr_data       in   data_len  host byte
//  full          out  1         FIFO holds DEPTH entries; writes are dropped
//  empty         out  1         FIFO holds 0 entries
//  baud_tick_tx  in   1         transmitter baud tick (1-clk pulse)
//  tx_done       in   1         transmitter frame-complete flag (may be level for >1 clk)
//  tx_start      out  1         start request to transmitter
//  tx_data       out  data_len  byte presented to transmitter; stable from LOAD until the next LOAD
//  busy          out  1         high when state != IDLE
// BEHAVIOUR
//  Reset (rst=0, async): rd_ptr=wr_ptr=0, count=0, state=IDLE, tx_start=0, tx_data=0, busy=0,
//   empty=1, full=0, tx_done_q=0. Queued bytes are discarded. Reset mid-frame just returns to
//   IDLE; the block does not abort a frame the transmitter has already started.
//  FIFO: count is 0..DEPTH (ADDR_W+1 bits). Pointers wrap modulo DEPTH. full=(count==DEPTH),
//   empty=(count==0); both are registered from count.
//  Write: if wr_en && !full, mem[wr_ptr]<=wr_data, wr_ptr++, count++.
//   If wr_en && full, the write is dropped and there is no other effect,
//   even if a pop happens in the same cycle.
//  Pop and write in the same cycle (not full): count is unchanged and both pointers advance.
//  FSM:
//   IDLE  : if !empty -> LOAD.
//   LOAD  : tx_data<=mem[rd_ptr], rd_ptr++, count-- (pop) -> START.
//   START : tx_start=1; hold until a cycle with baud_tick_tx=1 (tx_start is still 1 in that
//           cycle); next cycle tx_start=0 -> WAIT.
//   WAIT  : wait for a tx_done rising edge (tx_done & ~tx_done_q) -> IDLE.
//           A level-high tx_done left over from the previous frame is ignored.
//  Latency: a write into an empty, idle queue gives tx_start=1 three clk edges later
//   (write, IDLE->LOAD, LOAD->START). The first tx_start is high for 1..(clk/baud) cycles.
//  Back-to-back: after a tx_done edge the next byte reaches START 2 cycles later (IDLE, LOAD).
//  tx_start is never asserted while the FIFO is empty and no pop is in flight.
// CONFIGURATION
//  UART_TXQ_STATUS_EN defined: adds ports level (out, ADDR_W+1; equals count) and overflow
//   (out, 1). overflow is sticky: set on any write dropped while full; cleared only by reset
//   or by clr_ovf (in, 1; a clr_ovf and a drop in the same cycle leave overflow=1).
//  Not defined: these three ports and their logic do not exist, and drops are silent.
// TESTING
//  1) Reset with rst=0 mid-START, release -> tx_start=0, empty=1, busy=0, no spurious tx_start.
//  2) Write 0xA5 to an idle queue -> tx_start rises 3 clks later, tx_data=0xA5,
//     and it drops the cycle after baud_tick_tx.
//  3) Write 0x11,0x22,0x33 back-to-back -> three frames in order; each tx_start only after
//     the previous tx_done rising edge.
//  4) Write 17 bytes into DEPTH=16 with no ticks -> full=1 after 16; the 17th is dropped;
//     the drained order is bytes 1..16.
//  5) Hold wr_en every cycle during a drain -> pointers wrap past DEPTH-1, data order intact,
//     count never exceeds DEPTH.
//  6) With UART_TXQ_STATUS_EN: overflow a full queue -> overflow=1, level=16;
//     pulse clr_ovf -> overflow=0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// rtl/uart_tx_queue.sv - circular byte FIFO feeding the UART transmitter's tx_start/tx_data
// Optional status ports (level, overflow, clr_ovf) are enabled by defining UART_TXQ_STATUS_EN.
module uart_tx_queue #(
    parameter int data_len = 8,
    parameter int DEPTH    = 16,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [data_len-1:0] wr_data,
    output logic                full,
    output logic                empty,
    input  logic                baud_tick_tx,
    input  logic                tx_done,
    output logic                tx_start,
    output logic [data_len-1:0] tx_data,
    output logic                busy
`ifdef UART_TXQ_STATUS_EN
    ,
    input  logic                clr_ovf,
    output logic [ADDR_W:0]     level,
    output logic                overflow
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t              state, state_next;
    logic [data_len-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr, rd_ptr;
    logic [ADDR_W:0]     count, count_next;
    logic                tx_done_q;
    logic                push, pop;

    // A write arriving while full is dropped even if LOAD frees a slot in the same cycle.
    assign push = wr_en && !full;
    assign pop  = (state == LOAD);
    assign busy = (state != IDLE);

    always_comb begin
        count_next = count + {{ADDR_W{1'b0}}, push} - {{ADDR_W{1'b0}}, pop};
    end

    always_comb begin
        state_next = state;
        tx_start   = 1'b0;
        case (state)
            IDLE:  if (!empty) state_next = LOAD;
            LOAD:  state_next = START;
            START: begin
                tx_start = 1'b1;
                if (baud_tick_tx) state_next = WAIT;
            end
            WAIT:  if (tx_done && !tx_done_q) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            full      <= 1'b0;
            empty     <= 1'b1;
            tx_data   <= '0;
            tx_done_q <= 1'b0;
        end else begin
            state     <= state_next;
            tx_done_q <= tx_done;
            count     <= count_next;
            full      <= (count_next == FULL_COUNT);
            empty     <= (count_next == '0);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                tx_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + 1'b1;
            end
        end
    end

`ifdef UART_TXQ_STATUS_EN
    assign level = count;

    // A drop in the same cycle as clr_ovf wins, so no overflow is ever lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               overflow <= 1'b0;
        else if (wr_en && full) overflow <= 1'b1;
        else if (clr_ovf)       overflow <= 1'b0;
    end
`endif

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb/tb_uart_tx_queue.sv - directed self-checking bench for uart_tx_queue
module tb_uart_tx_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty;
    logic       baud_tick_tx = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       busy;
`ifdef UART_TXQ_STATUS_EN
    logic       clr_ovf = 1'b0;
    logic [4:0] level;
    logic       overflow;
`endif

    int checks = 0;
    int errors = 0;

    uart_tx_queue dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .baud_tick_tx (baud_tick_tx),
        .tx_done      (tx_done),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .busy         (busy)
`ifdef UART_TXQ_STATUS_EN
        ,
        .clr_ovf      (clr_ovf),
        .level        (level),
        .overflow     (overflow)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transmitter stand-in: waits for tx_start, gives one baud tick, then a 2-cycle tx_done level.
    task automatic run_frame(output logic [7:0] data, output bit timed_out, output bit dropped);
        int n = 0;
        while (tx_start !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        timed_out = (tx_start !== 1'b1);
        data = tx_data;
        baud_tick_tx = 1'b1;
        step();
        baud_tick_tx = 1'b0;
        dropped = (tx_start === 1'b0);
        tx_done = 1'b1;
        step();
        step();
        tx_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b expected 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b expected 0", full); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got %h expected 00", tx_data); end
        rst = 1'b1;
        step();
    endtask

    task automatic test_reset_mid_start();
        int spurious = 0;
        wr_data = 8'h5C; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL midrst_pre_start got %b expected 1", tx_start); end
        rst = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start got %b expected 0", tx_start); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b expected 0", busy); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL midrst_empty got %b expected 1", empty); end
        step();
        step();
        rst = 1'b1;
        repeat (8) begin
            step();
            if (tx_start !== 1'b0 || busy !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL midrst_spurious got %0d expected 0", spurious); end
    endtask

    task automatic test_single_byte();
        wr_data = 8'hA5; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_edge1 got start=%b busy=%b expected 0/0", tx_start, busy); end
        step();
        checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_edge2 got start=%b busy=%b expected 0/1", tx_start, busy); end
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_edge3_start got %b expected 1", tx_start); end
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL single_tx_data got %h expected a5", tx_data); end
        step();
        step();
        checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL single_hold got %b expected 1", tx_start); end
        baud_tick_tx = 1'b1;
        step();
        baud_tick_tx = 1'b0;
        checks++; if (tx_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_after_tick got start=%b busy=%b expected 0/1", tx_start, busy); end
        tx_done = 1'b1;
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got busy=%b expected 0", busy); end
        step();
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b expected 1", empty); end
    endtask

    // tx_done is still high from the previous frame on entry.
    task automatic test_back_to_back();
        logic [7:0] d;
        bit to, dr;
        int bad = 0;
        wr_en = 1'b1;
        wr_data = 8'h11; step();
        wr_data = 8'h22; step();
        wr_data = 8'h33; step();
        wr_en = 1'b0;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h11) begin errors++; $display("FAIL b2b_first got start=%b data=%h expected 1/11", tx_start, tx_data); end
        baud_tick_tx = 1'b1;
        step();
        baud_tick_tx = 1'b0;
        repeat (4) begin
            step();
            if (tx_start !== 1'b0 || busy !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL b2b_level_ignored got %0d bad cycles expected 0", bad); end
        tx_done = 1'b0;
        step();
        tx_done = 1'b1;
        step();
        checks++; if (tx_start !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got start=%b busy=%b expected 0/0", tx_start, busy); end
        step();
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL b2b_load got %b expected 0", tx_start); end
        step();
        tx_done = 1'b0;
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'h22) begin errors++; $display("FAIL b2b_second got start=%b data=%h expected 1/22", tx_start, tx_data); end
        run_frame(d, to, dr);
        checks++; if (d !== 8'h22 || to || !dr) begin errors++; $display("FAIL b2b_frame2 got data=%h to=%b dr=%b expected 22/0/1", d, to, dr); end
        run_frame(d, to, dr);
        checks++; if (d !== 8'h33 || to || !dr) begin errors++; $display("FAIL b2b_frame3 got data=%h to=%b dr=%b expected 33/0/1", d, to, dr); end
        checks++; if (empty !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_done got empty=%b busy=%b expected 1/0", empty, busy); end
    endtask

    // Head byte parks the FSM in START so no pops happen while filling.
    task automatic test_fill_drop();
        logic [7:0] d;
        bit to, dr;
        int spurious = 0;
        wr_data = 8'hF0; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        step();
        checks++; if (tx_start !== 1'b1 || tx_data !== 8'hF0) begin errors++; $display("FAIL fill_head got start=%b data=%h expected 1/f0", tx_start, tx_data); end
        for (int i = 1; i <= 17; i++) begin
            wr_en = 1'b1;
            wr_data = 8'(i);
            step();
            if (i == 15) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL fill_full_at15 got %b expected 0", full); end
            end
            if (i == 16) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full_at16 got %b expected 1", full); end
            end
        end
        wr_en = 1'b0;
        checks++; if (full !== 1'b1 || empty !== 1'b0) begin errors++; $display("FAIL fill_after17 got full=%b empty=%b expected 1/0", full, empty); end
        run_frame(d, to, dr);
        checks++; if (d !== 8'hF0 || to) begin errors++; $display("FAIL fill_drain_head got %h expected f0", d); end
        for (int i = 1; i <= 16; i++) begin
            run_frame(d, to, dr);
            checks++; if (d !== 8'(i) || to) begin errors++; $display("FAIL fill_drain_%0d got %h expected %h", i, d, 8'(i)); end
        end
        repeat (40) begin
            step();
            if (tx_start !== 1'b0) spurious++;
        end
        checks++; if (spurious != 0) begin errors++; $display("FAIL fill_no_17th got %0d start cycles expected 0", spurious); end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_empty got %b expected 1", empty); end
    endtask

    task automatic test_wrap_stream();
        logic [7:0] got [18];
        int full_seen = 0;
        int timeouts = 0;
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr_en = 1'b1;
                    wr_data = 8'h40 + 8'(i);
                    step();
                    if (full !== 1'b0) full_seen++;
                end
                wr_en = 1'b0;
            end
            begin
                for (int k = 0; k < 18; k++) begin
                    bit to, dr;
                    run_frame(got[k], to, dr);
                    if (to) timeouts++;
                end
            end
        join
        checks++; if (full_seen != 0) begin errors++; $display("FAIL wrap_full_seen got %0d expected 0", full_seen); end
        checks++; if (timeouts != 0) begin errors++; $display("FAIL wrap_timeouts got %0d expected 0", timeouts); end
        for (int k = 0; k < 18; k++) begin
            checks++; if (got[k] !== 8'h40 + 8'(k)) begin errors++; $display("FAIL wrap_data_%0d got %h expected %h", k, got[k], 8'h40 + 8'(k)); end
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got %b expected 1", empty); end
    endtask

`ifdef UART_TXQ_STATUS_EN
    task automatic test_status();
        for (int i = 1; i <= 18; i++) begin
            if (i == 18) begin
                checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stat_ovf_before got %b expected 0", overflow); end
            end
            wr_en = 1'b1;
            wr_data = 8'h80 + 8'(i);
            step();
        end
        wr_en = 1'b0;
        checks++; if (level !== 5'd16 || full !== 1'b1) begin errors++; $display("FAIL stat_level got level=%0d full=%b expected 16/1", level, full); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stat_ovf_set got %b expected 1", overflow); end
        wr_en = 1'b1;
        clr_ovf = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL stat_clr_with_drop got %b expected 1", overflow); end
        step();
        clr_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL stat_clr got %b expected 0", overflow); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL stat_level_kept got %0d expected 16", level); end
    endtask
`endif

    initial begin
        test_reset();
        test_reset_mid_start();
        test_single_byte();
        test_back_to_back();
        test_fill_drop();
        test_wrap_stream();
`ifdef UART_TXQ_STATUS_EN
        test_status();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
